// File: rtl/output_arb_pkg.sv
// Shared types for the output-port arbiter: FSM states, access size and requester limit.
package output_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } arb_state_t;

  typedef logic [1:0] size_t;

  localparam int MAX_REQ = 8;

endpackage

// File: rtl/rr_picker.sv
// Winner selection for the output arbiter: round-robin starting after 'last', or a
// lowest-index priority encoder when OUTPUT_ARB_FIXED_PRIO_EN is defined.
module rr_picker
  import output_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
`ifndef OUTPUT_ARB_FIXED_PRIO_EN
  input  logic [$clog2(NUM_REQ)-1:0] last,
`endif
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

  localparam int IDX_W = $clog2(NUM_REQ);

`ifdef OUTPUT_ARB_FIXED_PRIO_EN
  // Scanning from the top down lets the lowest set bit overwrite any higher one.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant     = '0;
        grant[i]  = 1'b1;
        grant_idx = IDX_W'(i);
      end
    end
  end
`else
  logic             found;
  logic [IDX_W-1:0] cand;

  // Visit last+1, last+2, ... wrapping, so the previous winner is checked last.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = IDX_W'((int'(last) + off) % NUM_REQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end
`endif

endmodule

// File: rtl/output_arbiter.sv
// Shares the memory-mapped output port among NUM_REQ requesters: grant, one-cycle issue, response.
// Define OUTPUT_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module output_arbiter
  import output_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]   req_address,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0][1:0]          req_size,
  input  logic [NUM_REQ-1:0]               req_write,
  output logic [NUM_REQ-1:0]               resp_valid,
  output logic [DATA_W-1:0]                resp_data,
  output logic [ADDR_W-1:0]                output_address,
  output logic [DATA_W-1:0]                output_in,
  output logic [1:0]                       output_size,
  output logic                             output_write_enable,
  input  logic [DATA_W-1:0]                output_out
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t       state;
  arb_state_t       next_state;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] owner;
  logic             take;
  size_t            size_q;

`ifndef OUTPUT_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0] last;
`endif

  rr_picker #(
    .NUM_REQ(NUM_REQ)
  ) u_picker (
    .req      (req_valid),
`ifndef OUTPUT_ARB_FIXED_PRIO_EN
    .last     (last),
`endif
    .grant    (grant),
    .grant_idx(grant_idx)
  );

  assign take        = (state == IDLE) && (|req_valid);
  assign output_size = size_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (|req_valid) next_state = ISSUE;
      ISSUE:   next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Ready is held low during reset so a waiting requester never sees a phantom accept.
  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    resp_data  = '0;
    if (state == IDLE && !rst) begin
      req_ready = grant;
    end
    if (state == RESP) begin
      resp_valid[owner] = 1'b1;
      resp_data         = output_out;
    end
  end

  // The payload registers double as the output map drive; only the write enable is pulsed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner               <= '0;
`ifndef OUTPUT_ARB_FIXED_PRIO_EN
      last                <= IDX_W'(NUM_REQ - 1);
`endif
      output_address      <= '0;
      output_in           <= '0;
      size_q              <= '0;
      output_write_enable <= 1'b0;
    end else begin
      output_write_enable <= 1'b0;
      if (take) begin
        owner               <= grant_idx;
`ifndef OUTPUT_ARB_FIXED_PRIO_EN
        last                <= grant_idx;
`endif
        output_address      <= req_address[grant_idx];
        output_in           <= req_data[grant_idx];
        size_q              <= req_size[grant_idx];
        output_write_enable <= req_write[grant_idx];
      end
    end
  end

endmodule

// File: tb/tb_output_arbiter.sv
// Self-checking bench for output_arbiter: transaction-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_output_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int IDX_W   = $clog2(NUM_REQ);

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_address;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0][1:0]        req_size;
  logic [NUM_REQ-1:0]             req_write;
  logic [NUM_REQ-1:0]             resp_valid;
  logic [DATA_W-1:0]              resp_data;
  logic [ADDR_W-1:0]              output_address;
  logic [DATA_W-1:0]              output_in;
  logic [1:0]                     output_size;
  logic                           output_write_enable;
  logic [DATA_W-1:0]              output_out;

  int errors = 0;
  int checks = 0;

  output_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_address        (req_address),
    .req_data           (req_data),
    .req_size           (req_size),
    .req_write          (req_write),
    .resp_valid         (resp_valid),
    .resp_data          (resp_data),
    .output_address     (output_address),
    .output_in          (output_in),
    .output_size        (output_size),
    .output_write_enable(output_write_enable),
    .output_out         (output_out)
  );

  always #5 clk = ~clk;

  // Output map: small register file, write commits on the clock edge, combinational readback.
  logic [DATA_W-1:0] map_mem [16] = '{default: '0};
  always @(posedge clk) begin
    if (output_write_enable) map_mem[output_address[3:0]] <= output_in;
  end
  assign output_out = map_mem[output_address[3:0]];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkTrue(input string name, input bit cond, input int actual);
    checks++;
    if (!cond) begin
      errors++;
      $display("[TB] FAIL %s: got %0d outside required bound", name, actual);
    end
  endtask

  // Transaction-level model: a pending transaction lives for three cycles
  // (grant, issue, respond); winners are found by scanning after the previous one.
  int                m_phase = 0;
  int                m_owner = 0;
  int                m_prev  = NUM_REQ - 1;
  logic              m_write = 1'b0;
  logic [ADDR_W-1:0] m_addr  = '0;
  logic [DATA_W-1:0] m_data  = '0;
  logic [1:0]        m_size  = '0;
  logic [DATA_W-1:0] m_mem [16] = '{default: '0};

  logic [NUM_REQ-1:0] ready_s = '0;
  int  g_idx[$];
  int  g_cyc[$];
  int  cycle = 0;
  int  we_count = 0;
  int  resp_count = 0;
  int  last_resp_owner = -1;
  logic [DATA_W-1:0] last_resp_data = '0;
  int  phase = 0;
  int  streak[NUM_REQ] = '{default: 0};
  int  max_wait[NUM_REQ] = '{default: 0};
  int  grants5[NUM_REQ] = '{default: 0};

  always @(negedge clk) begin
    logic [NUM_REQ-1:0] exp_ready;
    logic [NUM_REQ-1:0] exp_resp;
    logic [DATA_W-1:0]  exp_rdata;
    logic               exp_we;
    logic [IDX_W-1:0]   wi;
    int w;
    int c;
    cycle++;
    if (rst) begin
      m_phase = 0;
      m_prev  = NUM_REQ - 1;
      m_write = 1'b0;
      m_addr  = '0;
      m_data  = '0;
      m_size  = '0;
    end
    exp_ready = '0;
    exp_resp  = '0;
    exp_rdata = '0;
    exp_we    = 1'b0;
    w = -1;
    if (!rst && m_phase == 0) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        c = (m_prev + k) % NUM_REQ;
        if (w < 0 && ((req_valid >> c) & NUM_REQ'(1)) != 0) w = c;
      end
    end
    if (w >= 0) exp_ready = NUM_REQ'(1) << w;
    if (m_phase == 2) exp_we = m_write;
    if (m_phase == 1) begin
      exp_resp  = NUM_REQ'(1) << m_owner;
      exp_rdata = m_mem[m_addr[3:0]];
    end
    checkOutput("model_req_ready", req_ready, exp_ready);
    checkOutput("model_resp_valid", resp_valid, exp_resp);
    checkOutput("model_resp_data", resp_data, exp_rdata);
    checkOutput("model_write_enable", output_write_enable, exp_we);
    checkOutput("model_address", output_address, m_addr);
    checkOutput("model_in", output_in, m_data);
    checkOutput("model_size", output_size, m_size);

    for (int i = 0; i < NUM_REQ; i++) begin
      if (((req_ready >> i) & NUM_REQ'(1)) != 0) begin
        g_idx.push_back(i);
        g_cyc.push_back(cycle);
        if (phase == 5) grants5[i]++;
      end
      if (phase == 5) begin
        if (((req_valid >> i) & NUM_REQ'(1)) != 0 && ((req_ready >> i) & NUM_REQ'(1)) == 0) streak[i]++;
        else streak[i] = 0;
        if (streak[i] > max_wait[i]) max_wait[i] = streak[i];
      end
      if (((resp_valid >> i) & NUM_REQ'(1)) != 0) begin
        resp_count++;
        last_resp_owner = i;
        last_resp_data  = resp_data;
      end
    end
    if (output_write_enable) we_count++;
    ready_s = req_ready;

    if (!rst) begin
      case (m_phase)
        0: if (w >= 0) begin
          wi      = IDX_W'(w);
          m_owner = w;
`ifndef OUTPUT_ARB_FIXED_PRIO_EN
          m_prev  = w;
`endif
          m_addr  = req_address[wi];
          m_data  = req_data[wi];
          m_size  = req_size[wi];
          m_write = req_write[wi];
          m_phase = 2;
        end
        2: begin
          if (m_write) m_mem[m_addr[3:0]] = m_data;
          m_phase = 1;
        end
        default: m_phase = 0;
      endcase
    end
  end

  logic [NUM_REQ-1:0] keep_valid = '0;

  // Advance one clock; requesters that were accepted drop their valid unless told to keep it.
  task automatic nextCycle();
    @(posedge clk);
    #1;
    req_valid = req_valid & ~(ready_s & ~keep_valid);
  endtask

  task automatic applyStimulus(input int idx, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                               input logic [1:0] size, input logic write);
    logic [IDX_W-1:0] ix;
    ix = IDX_W'(idx);
    req_address[ix] = addr;
    req_data[ix]    = data;
    req_size[ix]    = size;
    req_write[ix]   = write;
    req_valid[ix]   = 1'b1;
  endtask

  initial begin
    int gstart;
    int we_before;
    int resp_before;
    req_valid   = '0;
    req_address = '0;
    req_data    = '0;
    req_size    = '0;
    req_write   = '0;

    #1 rst = 1'b1;
    @(negedge clk);
    req_valid = '1;
    @(negedge clk);
    checkOutput("reset_req_ready", req_ready, 0);
    checkOutput("reset_write_enable", output_write_enable, 0);
    checkOutput("reset_address", output_address, 0);
    checkOutput("reset_resp_data", resp_data, 0);
    req_valid = '0;
    nextCycle();
    rst = 1'b0;

    $display("[TB] requester 0 writes 0x5A");
    nextCycle();
    applyStimulus(0, 32'h0, 32'h5A, 2'b10, 1'b1);
    @(negedge clk);
    checkOutput("t1_grant", req_ready, 2'b01);
    nextCycle();
    @(negedge clk);
    checkOutput("t1_write_enable", output_write_enable, 1);
    checkOutput("t1_output_in", output_in, 32'h5A);
    nextCycle();
    @(negedge clk);
    checkOutput("t1_resp_valid", resp_valid, 2'b01);
    checkOutput("t1_resp_data", resp_data, 32'h5A);
    nextCycle();
    @(negedge clk);
    checkOutput("t1_we_cleared", output_write_enable, 0);
    checkOutput("t1_payload_held", output_in, 32'h5A);

    nextCycle();
    rst = 1'b1;
    @(negedge clk);
    nextCycle();
    rst = 1'b0;

    $display("[TB] both requesters write");
    gstart = g_idx.size();
    applyStimulus(0, 32'h0, 32'h11, 2'b10, 1'b1);
    applyStimulus(1, 32'h0, 32'h22, 2'b10, 1'b1);
    repeat (8) nextCycle();
    checkOutput("t2_grant_count", g_idx.size() - gstart, 2);
    if (g_idx.size() >= gstart + 2) begin
      checkOutput("t2_first_winner", g_idx[gstart], 0);
      checkOutput("t2_second_winner", g_idx[gstart+1], 1);
      checkOutput("t2_grant_spacing", g_cyc[gstart+1] - g_cyc[gstart], 3);
    end
    checkOutput("t2_final_readback", last_resp_data, 32'h22);
    checkOutput("t2_final_owner", last_resp_owner, 1);

    $display("[TB] requester 1 reads back");
    we_before   = we_count;
    resp_before = resp_count;
    applyStimulus(1, 32'h0, 32'h99, 2'b00, 1'b0);
    repeat (5) nextCycle();
    checkOutput("t3_no_write", we_count, we_before);
    checkOutput("t3_resp_count", resp_count, resp_before + 1);
    checkOutput("t3_readback", last_resp_data, 32'h22);

    $display("[TB] reset during issue");
    applyStimulus(0, 32'h0, 32'hFF, 2'b10, 1'b1);
    @(negedge clk);
    checkOutput("t4_grant", req_ready, 2'b01);
    resp_before = resp_count;
    nextCycle();
    checkOutput("t4_we_before_reset", output_write_enable, 1);
    rst = 1'b1;
    #1;
    checkOutput("t4_we_reset", output_write_enable, 0);
    checkOutput("t4_address_reset", output_address, 0);
    checkOutput("t4_in_reset", output_in, 0);
    checkOutput("t4_size_reset", output_size, 0);
    checkOutput("t4_resp_reset", resp_valid, 0);
    @(negedge clk);
    nextCycle();
    rst = 1'b0;
    repeat (4) nextCycle();
    checkOutput("t4_led_kept", map_mem[0], 32'h22);
    checkOutput("t4_no_resp", resp_count, resp_before);

    $display("[TB] requester 1 continuous, requester 0 pulsing");
    phase = 5;
    keep_valid = 2'b10;
    applyStimulus(1, 32'h0, 32'h0, 2'b00, 1'b0);
    for (int i = 0; i < 30; i++) begin
      if (i % 4 == 0) applyStimulus(0, 32'h0, 32'h0, 2'b00, 1'b0);
      if (i % 4 == 2) req_valid[0] = 1'b0;
      nextCycle();
    end
    keep_valid = '0;
    req_valid  = '0;
    phase = 0;
    repeat (4) nextCycle();
`ifndef OUTPUT_ARB_FIXED_PRIO_EN
    checkTrue("t5_wait_req1", max_wait[1] <= 6, max_wait[1]);
`endif
    checkTrue("t5_wait_req0", max_wait[0] <= 6, max_wait[0]);
    checkTrue("t5_grants_req0", grants5[0] > 0, grants5[0]);
    checkTrue("t5_grants_req1", grants5[1] > 0, grants5[1]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/output_arbiter.md
# output_arbiter

Shares the single memory-mapped output port (address/data/size/write-enable in, 32-bit readback out) between `NUM_REQ` bus requesters, e.g. the core's store path and the debug bridge. Each requester hands over one transaction through a valid/ready handshake. The arbiter issues it to the output map for exactly one cycle, then returns the map's readback value with a one-cycle response strobe. It sits between the requesters and the output map and is the only driver of the map's input ports.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters; legal range 2..8.
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.

Ports:
- `clk`  in  1  system clock; everything is on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `req_valid`  in  `[NUM_REQ]`  requester holds a transaction.
- `req_ready`  out  `[NUM_REQ]`  transaction accepted this cycle.
- `req_address`  in  `[NUM_REQ][ADDR_W]`  target output address.
- `req_data`  in  `[NUM_REQ][DATA_W]`  write data.
- `req_size`  in  `[NUM_REQ][2]`  access size; passed through untouched.
- `req_write`  in  `[NUM_REQ]`  1 = write, 0 = read.
- `resp_valid`  out  `[NUM_REQ]`  one-cycle response strobe to the owning requester.
- `resp_data`  out  `DATA_W`  readback; meaningful only while some `resp_valid` bit is 1, otherwise 0.
- `output_address`  out  `ADDR_W`  to the output map.
- `output_in`  out  `DATA_W`  to the output map.
- `output_size`  out  2  to the output map.
- `output_write_enable`  out  1  to the output map.
- `output_out`  in  `DATA_W`  readback from the output map (combinational on its side).

## Operation
- FSM states: IDLE, ISSUE, RESP; reset state is IDLE.
- IDLE:
  - If any `req_valid` is 1, the picker selects a winner `g`.
  - `req_ready[g]` is 1 combinationally in that cycle, one-hot.
  - At the clock edge, latch address, data, size, write and owner `g`, then go to ISSUE.
  - If no `req_valid` is 1, stay in IDLE.
- ISSUE:
  - `output_*` are driven from the latches.
  - `output_write_enable` equals the latched write bit for this single cycle.
  - Always go to RESP.
- RESP:
  - `resp_valid[owner]` is 1.
  - `resp_data` = `output_out`, which already reflects the write committed at the ISSUE edge.
  - Always go to IDLE.
- Round-robin arbitration:
  - Pointer `last` holds the most recent winner; its reset value is `NUM_REQ-1`, so requester 0 wins first.
  - The search starts at `last+1` and wraps modulo `NUM_REQ`.
  - `last` updates only on a grant.
- A requester must hold `req_valid` and its payload stable until it sees `req_ready`. Dropping `req_valid` before the grant is legal: the request is simply withdrawn.
- Requests that are valid while the FSM is in ISSUE or RESP are ignored; `req_ready` is 0 in those states.
- The latched address/data/size keep driving `output_*` between transactions. Only `output_write_enable` qualifies a write.
- Reset mid-transaction:
  - The FSM goes to IDLE and the in-flight transaction is dropped.
  - No write enable or response is produced for it.
  - `last` returns to `NUM_REQ-1`.

## Timing
- Reset values:
  - `req_ready` = 0, `resp_valid` = 0, `resp_data` = 0.
  - `output_address` = 0, `output_in` = 0, `output_size` = 0, `output_write_enable` = 0.
- Latency from grant cycle to write-enable cycle: 1 cycle. From grant to `resp_valid`: 2 cycles.
- Throughput: one transaction per 3 cycles.
- `req_ready` is a combinational function of state, `req_valid` and `last`. All `output_*` ports are registered. `resp_data` is a combinational mux in RESP.
- With all requesters continuously valid, each one receives a grant once every `3*NUM_REQ` cycles.

## Configuration
- `OUTPUT_ARB_FIXED_PRIO_EN` defined: fixed priority, where the lowest-index valid requester always wins. `last` is not implemented.
- Undefined (default): round-robin as described above.

## Structure
- Package `output_arb_pkg`:
  - state enum `arb_state_t` {IDLE, ISSUE, RESP};
  - `size_t` (2-bit access size);
  - constant `MAX_REQ = 8`.
- Sub-module `rr_picker`, parameterised by `NUM_REQ`:
  - inputs: request vector and `last`;
  - outputs: one-hot grant and grant index;
  - under the macro it reduces to a lowest-set-bit priority encoder.

## Test plan
- Reset, then requester 0 writes 0x5A to address 0:
  - `output_write_enable` = 1 exactly one cycle after `req_ready[0]`;
  - the next cycle shows `resp_valid[0]` = 1 with `resp_data` = 0x5A.
- Both requesters valid at once (0 writes 0x11, 1 writes 0x22):
  - grant order is 0 then 1, with grants 3 cycles apart;
  - final readback is 0x22;
  - with the macro defined, a still-valid requester 0 blocks requester 1.
- Requester 1 reads address 0 after the LED register holds 0x22: no write enable, `resp_data` = 0x22.
- Assert `rst` during ISSUE of a write of 0xFF:
  - all outputs go to their reset values immediately;
  - the LED register keeps its old value and no `resp_valid` appears.
- Requester 1 continuously valid and requester 0 pulsing: no requester waits more than 6 cycles for a grant, and `req_ready` stays 0 during ISSUE/RESP.
